// File: rtl/mips_pipe_pkg.sv
// Shared pipeline payload types for the SimMIPS core.
// Stage field widths, payload structs and occupancy states.
package mips_pipe_pkg;

  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 9;
  localparam int IDEX_DATA_W  = 111;
  localparam int EXMEM_CTRL_W = 4;
  localparam int EXMEM_DATA_W = 69;
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 69;

  typedef struct packed {
    logic        valid_instr;
  } ifid_ctrl_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } ifid_data_t;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic [2:0] aluop;
    logic       regwr;
    logic       memtoreg;
    logic       memwr;
    logic       dmen;
  } idex_ctrl_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
  } idex_data_t;

  typedef struct packed {
    logic regwr;
    logic memtoreg;
    logic memwr;
    logic dmen;
  } exmem_ctrl_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] rt;
    logic [4:0]  regdst_addr;
  } exmem_data_t;

  typedef struct packed {
    logic regwr;
    logic memtoreg;
  } memwb_ctrl_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] result;
    logic [4:0]  regdst_addr;
  } memwb_data_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

  function automatic occ_state_e occ_state(
    input logic main_v,
    input logic skid_v
  );
    if (skid_v)
      return FULL;
    else if (main_v)
      return HALF;
    else
      return EMPTY;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// One pipeline storage slot: valid bit plus ctrl/data fields.
// Flush clears only the valid bit; fields may keep stale values.
module pipe_entry #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 69
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic              drop,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [DATA_W-1:0] data_d,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // valid: flush beats load, load beats drop
  always_ff @(posedge clk) begin
    if (reset)
      valid <= 1'b0;
    else if (flush)
      valid <= 1'b0;
    else if (load)
      valid <= 1'b1;
    else if (drop)
      valid <= 1'b0;
  end

  // payload fields capture on load only
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= '0;
      data <= '0;
    end else if (load && !flush) begin
      ctrl <= ctrl_d;
      data <= data_d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flush.
// SKID=1 adds a second entry so in_ready comes from a flop.
module pipe_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  logic              main_v;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_v;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic              main_load;
  logic              main_drop;
  logic              main_sel_skid;
  logic              skid_load;
  logic              skid_drop;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] main_data_d;

  logic              in_xfer;
  logic              out_xfer;
  logic              rdy_q;
  occ_state_e        state;
  occ_state_e        nxt;

  assign state    = occ_state(main_v, skid_v);
  assign in_xfer  = in_valid & in_ready & ~flush;
  assign out_xfer = main_v & out_ready;

  assign main_ctrl_d = main_sel_skid ? skid_ctrl : in_ctrl;
  assign main_data_d = main_sel_skid ? skid_data : in_data;

  pipe_entry #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .load  (main_load),
    .drop  (main_drop),
    .ctrl_d(main_ctrl_d),
    .data_d(main_data_d),
    .valid (main_v),
    .ctrl  (main_ctrl),
    .data  (main_data)
  );

  if (SKID != 0) begin : g_skid
    pipe_entry #(
      .CTRL_W(CTRL_W),
      .DATA_W(DATA_W)
    ) u_skid (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .load  (skid_load),
      .drop  (skid_drop),
      .ctrl_d(in_ctrl),
      .data_d(in_data),
      .valid (skid_v),
      .ctrl  (skid_ctrl),
      .data  (skid_data)
    );
  end else begin : g_noskid
    assign skid_v    = 1'b0;
    assign skid_ctrl = '0;
    assign skid_data = '0;
  end

  // next occupancy and per-entry load/drop strobes
  always_comb begin
    nxt           = state;
    main_load     = 1'b0;
    main_drop     = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_drop     = 1'b0;
    if (SKID != 0) begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_load = 1'b1;
            nxt       = HALF;
          end
        end
        HALF: begin
          if (in_xfer && out_ready) begin
            main_load = 1'b1;
          end else if (in_xfer) begin
            skid_load = 1'b1;
            nxt       = FULL;
          end else if (out_ready) begin
            main_drop = 1'b1;
            nxt       = EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
            skid_drop     = 1'b1;
            nxt           = HALF;
          end
        end
        default: nxt = EMPTY;
      endcase
    end else begin
      main_load = in_xfer;
      main_drop = out_xfer & ~in_xfer;
      if (in_xfer || (main_v && !main_drop))
        nxt = HALF;
      else
        nxt = EMPTY;
    end
    if (flush)
      nxt = EMPTY;
  end

  // registered ready: low exactly while the stage is FULL
  always_ff @(posedge clk) begin
    if (reset)
      rdy_q <= 1'b1;
    else
      rdy_q <= (nxt != FULL);
  end

  assign in_ready  = (SKID != 0) ? rdy_q : (~main_v | out_ready);
  assign out_valid = main_v;
  assign out_ctrl  = main_ctrl & {CTRL_W{main_v}};
  assign out_data  = main_data;
  assign occ       = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg in both SKID modes.
// Expected payloads queue up at issue; monitors pop on output transfer.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [3:0]  c;
    logic [68:0] d;
  } exp_t;

  logic        clk = 1'b0;
  int          checks = 0;
  int          errors = 0;
  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        ea;
  exp_t        eb;

  logic        a_reset, a_flush, a_in_valid, a_in_ready;
  logic [3:0]  a_in_ctrl, a_out_ctrl;
  logic [68:0] a_in_data, a_out_data;
  logic        a_out_valid, a_out_ready;
  logic [1:0]  a_occ;

  logic        b_reset, b_flush, b_in_valid, b_in_ready;
  logic [3:0]  b_in_ctrl, b_out_ctrl;
  logic [68:0] b_in_data, b_out_data;
  logic        b_out_valid, b_out_ready;
  logic [1:0]  b_occ;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(4), .DATA_W(69), .SKID(1)) u_a (
    .clk      (clk),
    .reset    (a_reset),
    .flush    (a_flush),
    .in_valid (a_in_valid),
    .in_ready (a_in_ready),
    .in_ctrl  (a_in_ctrl),
    .in_data  (a_in_data),
    .out_valid(a_out_valid),
    .out_ready(a_out_ready),
    .out_ctrl (a_out_ctrl),
    .out_data (a_out_data),
    .occ      (a_occ)
  );

  pipe_stage_reg #(.CTRL_W(4), .DATA_W(69), .SKID(0)) u_b (
    .clk      (clk),
    .reset    (b_reset),
    .flush    (b_flush),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .in_ctrl  (b_in_ctrl),
    .in_data  (b_in_data),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready),
    .out_ctrl (b_out_ctrl),
    .out_data (b_out_data),
    .occ      (b_occ)
  );

  task automatic chk(input string name, input logic [68:0] act,
                     input logic [68:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [3:0] c,
                         input logic [68:0] d);
    a_in_valid = v;
    a_in_ctrl  = c;
    a_in_data  = d;
  endtask

  task automatic b_drive(input logic v, input logic [3:0] c,
                         input logic [68:0] d);
    b_in_valid = v;
    b_in_ctrl  = c;
    b_in_data  = d;
  endtask

  // monitor A: every output transfer must match the queue head
  always @(negedge clk) begin
    if (!a_reset && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_extra actual=%0h required=none", a_out_data);
      end else begin
        ea = qa.pop_front();
        chk("a_ctrl", 69'(a_out_ctrl), 69'(ea.c));
        chk("a_data", a_out_data, ea.d);
      end
    end
  end

  // monitor B: same for the single-register instance
  always @(negedge clk) begin
    if (!b_reset && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_extra actual=%0h required=none", b_out_data);
      end else begin
        eb = qb.pop_front();
        chk("b_ctrl", 69'(b_out_ctrl), 69'(eb.c));
        chk("b_data", b_out_data, eb.d);
      end
    end
  end

  initial begin
    a_reset = 1; a_flush = 0; a_out_ready = 0;
    b_reset = 1; b_flush = 0; b_out_ready = 0;
    a_drive(0, 0, 0);
    b_drive(0, 0, 0);
    tick;
    tick;
    a_reset = 0;
    b_reset = 0;
    @(negedge clk);
    chk("a_rst_valid", 69'(a_out_valid), 0);
    chk("a_rst_ctrl", 69'(a_out_ctrl), 0);
    chk("a_rst_data", a_out_data, 0);
    chk("a_rst_occ", 69'(a_occ), 0);
    chk("a_rst_ready", 69'(a_in_ready), 1);
    chk("b_rst_valid", 69'(b_out_valid), 0);
    chk("b_rst_ready", 69'(b_in_ready), 1);
    tick;

    // first payload, one-cycle latency
    a_drive(1, 4'hF, 69'h5A);
    qa.push_back({4'hF, 69'h5A});
    tick;
    a_in_valid = 0;
    @(negedge clk);
    chk("a_first_valid", 69'(a_out_valid), 1);
    chk("a_first_ctrl", 69'(a_out_ctrl), 69'hF);
    chk("a_first_data", a_out_data, 69'h5A);
    chk("a_first_occ", 69'(a_occ), 1);
    tick;

    // streaming at full rate
    a_out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      a_drive(1, 4'(i), 69'(i));
      qa.push_back({4'(i), 69'(i)});
      @(negedge clk);
      chk("a_stream_occ", 69'(a_occ), 1);
      chk("a_stream_ready", 69'(a_in_ready), 1);
      tick;
    end
    a_in_valid = 0;
    @(negedge clk);
    tick;

    // backpressure: A, B fill both entries, C held off
    a_out_ready = 0;
    a_drive(1, 4'h1, 69'hA);
    qa.push_back({4'h1, 69'hA});
    tick;
    a_drive(1, 4'h2, 69'hB);
    qa.push_back({4'h2, 69'hB});
    tick;
    a_drive(1, 4'h3, 69'hC);
    @(negedge clk);
    chk("a_bp_occ", 69'(a_occ), 2);
    chk("a_bp_ready", 69'(a_in_ready), 0);
    chk("a_bp_head", a_out_data, 69'hA);
    tick;
    @(negedge clk);
    chk("a_bp_hold_occ", 69'(a_occ), 2);
    chk("a_bp_hold_head", a_out_data, 69'hA);
    tick;
    qa.push_back({4'h3, 69'hC});
    a_out_ready = 1;
    @(negedge clk);
    tick;
    @(negedge clk);
    chk("a_drain_ready", 69'(a_in_ready), 1);
    chk("a_drain_occ", 69'(a_occ), 1);
    tick;
    a_in_valid = 0;
    @(negedge clk);
    chk("a_c_occ", 69'(a_occ), 1);
    tick;

    // flush while FULL with an offered payload
    a_out_ready = 0;
    a_drive(1, 4'h5, 69'h111);
    tick;
    a_drive(1, 4'h6, 69'h222);
    tick;
    a_drive(1, 4'h7, 69'hDEAD);
    a_flush = 1;
    @(negedge clk);
    chk("a_prefl_occ", 69'(a_occ), 2);
    tick;
    a_flush = 0;
    a_in_valid = 0;
    @(negedge clk);
    chk("a_fl_occ", 69'(a_occ), 0);
    chk("a_fl_valid", 69'(a_out_valid), 0);
    chk("a_fl_ctrl", 69'(a_out_ctrl), 0);
    chk("a_fl_ready", 69'(a_in_ready), 1);
    tick;
    a_out_ready = 1;
    tick;
    tick;

    // flush in HALF drops an input that in_ready would accept
    a_out_ready = 0;
    a_drive(1, 4'h8, 69'h333);
    tick;
    a_drive(1, 4'h9, 69'h444);
    a_flush = 1;
    @(negedge clk);
    chk("a_flh_ready", 69'(a_in_ready), 1);
    tick;
    a_flush = 0;
    a_in_valid = 0;
    @(negedge clk);
    chk("a_flh_occ", 69'(a_occ), 0);
    chk("a_flh_valid", 69'(a_out_valid), 0);
    tick;

    // consumption coinciding with flush still transfers
    a_drive(1, 4'hA, 69'h555);
    qa.push_back({4'hA, 69'h555});
    tick;
    a_in_valid = 0;
    a_out_ready = 1;
    a_flush = 1;
    @(negedge clk);
    tick;
    a_flush = 0;
    @(negedge clk);
    chk("a_flc_occ", 69'(a_occ), 0);
    tick;

    // reset with both entries held
    a_out_ready = 0;
    a_drive(1, 4'hB, 69'h666);
    tick;
    a_drive(1, 4'hC, 69'h777);
    tick;
    a_in_valid = 0;
    @(negedge clk);
    chk("a_prerst_occ", 69'(a_occ), 2);
    tick;
    a_reset = 1;
    tick;
    a_reset = 0;
    @(negedge clk);
    chk("a_mrst_occ", 69'(a_occ), 0);
    chk("a_mrst_valid", 69'(a_out_valid), 0);
    chk("a_mrst_ctrl", 69'(a_out_ctrl), 0);
    chk("a_mrst_data", a_out_data, 0);
    chk("a_mrst_ready", 69'(a_in_ready), 1);
    tick;

    // SKID=0: stall holds head, ready is combinational
    b_drive(1, 4'h3, 69'h77);
    qb.push_back({4'h3, 69'h77});
    tick;
    b_drive(1, 4'h4, 69'h88);
    @(negedge clk);
    chk("b_st_ready", 69'(b_in_ready), 0);
    chk("b_st_occ", 69'(b_occ), 1);
    chk("b_st_data", b_out_data, 69'h77);
    tick;
    @(negedge clk);
    chk("b_hold_data", b_out_data, 69'h77);
    tick;
    qb.push_back({4'h4, 69'h88});
    b_out_ready = 1;
    @(negedge clk);
    chk("b_swap_ready", 69'(b_in_ready), 1);
    tick;
    b_in_valid = 0;
    b_out_ready = 0;
    @(negedge clk);
    chk("b_swap_occ", 69'(b_occ), 1);
    chk("b_swap_data", b_out_data, 69'h88);
    chk("b_swap_ctrl", 69'(b_out_ctrl), 69'h4);
    tick;

    // SKID=0 streaming
    b_out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      b_drive(1, 4'(i + 8), 69'(i * 3));
      qb.push_back({4'(i + 8), 69'(i * 3)});
      @(negedge clk);
      chk("b_stream_occ", 69'(b_occ), 1);
      chk("b_stream_ready", 69'(b_in_ready), 1);
      tick;
    end
    b_in_valid = 0;
    @(negedge clk);
    tick;
    @(negedge clk);
    chk("b_end_occ", 69'(b_occ), 0);
    chk("b_end_ctrl", 69'(b_out_ctrl), 0);

    tick;
    tick;
    chk("a_left", 69'(qa.size()), 0);
    chk("b_left", 69'(qb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic, parametrised pipeline stage register for the SimMIPS core, replacing the fixed-field per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block. It carries an opaque payload split into a control field and a data field, with a valid/ready handshake, synchronous flush (bubble insertion), and an optional two-entry skid buffer. With the skid buffer enabled, the ready path is registered, which breaks the combinational stall chain between stages.

## Interface
- CTRL_W, 4: control bits (regwr, memtoreg, memwr, dmen for EX/MEM); forced to 0 on output when out_valid=0.
- DATA_W, 69: data bits (result, rt, regdst_addr for EX/MEM); never masked.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high; clock clk.
- flush  in  1  synchronous kill of all held entries; also drops the input in the same cycle.
- in_valid  in  1  upstream presents a payload.
- in_ready  out  1  stage accepts the payload; transfer when in_valid & in_ready & !flush.
- in_ctrl  in  CTRL_W  control field of the input payload.
- in_data  in  DATA_W  data field of the input payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes; transfer when out_valid & out_ready.
- out_ctrl  out  CTRL_W  head control field, ANDed with out_valid.
- out_data  out  DATA_W  head data field.
- occ  out  2  number of held entries, 0..2.

## Operation
- Storage: main entry (head) and, when SKID=1, a skid entry. Each entry has its own valid bit, ctrl field and data field.
- State machine for SKID=1, with the state encoded by the entry valid bits:
  - EMPTY:
    - in_xfer → main ← in; go to HALF.
  - HALF:
    - in_xfer & out_ready → main ← in; stay in HALF.
    - in_xfer & !out_ready → skid ← in; go to FULL.
    - !in_xfer & out_ready → go to EMPTY.
    - Otherwise hold.
  - FULL:
    - out_ready → main ← skid; go to HALF.
    - Otherwise hold. No input is accepted in FULL.
- in_ready for SKID=1 = (state != FULL). It is a flop output only and has no combinational path from out_ready.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - main loads on in_xfer.
  - out_valid clears when the head is consumed and nothing is accepted.
- Ordering is strictly FIFO; there is no reordering and no duplication.
- Flush:
  - Next state is EMPTY and all valid bits clear.
  - Flush overrides any simultaneous in_xfer; the input is dropped even though in_ready may read 1.
  - Data fields may hold stale values. out_ctrl is 0 because it is masked by out_valid.
  - A downstream consumption in the same cycle as flush still counts as a transfer (the head was valid that cycle).
- Reset:
  - All valid bits clear and occ = 0.
  - Ctrl and data registers go to 0.
  - in_ready = 1 after reset.
  - Reset mid-operation discards all entries, the same as flush.
- occ = main.valid + skid.valid.

## Timing
- Latency: payload accepted at edge N is visible on out_* after edge N (usable in cycle N+1).
- Throughput: one transfer per cycle sustained when out_ready=1, in both SKID modes.
- SKID=1: in_ready falls on the cycle after the second entry is captured, and rises on the cycle after FULL drains to HALF.
- Output values after reset: out_valid=0, out_ctrl=0, out_data=0, occ=0, in_ready=1.

## Structure
- Shared package mips_pipe_pkg contains:
  - Per-stage CTRL_W/DATA_W constants (EXMEM_CTRL_W=4, EXMEM_DATA_W=69, and the others).
  - Packed struct typedefs for each stage payload.
  - Occupancy state enum: EMPTY, HALF, FULL.
- The entry storage (valid + ctrl + data flop, synchronous clear) is natural as a sub-module pipe_entry, instantiated once or twice.
- The control FSM stays in the top.

## Test plan
- Reset → out_valid=0, out_ctrl=0, out_data=0, occ=0, in_ready=1. Then in_valid=1, in_ctrl=4'hF, in_data=69'h5A → next cycle out_valid=1, out_ctrl=4'hF, out_data=69'h5A.
- SKID=1 streaming: out_ready=1, payloads 1..8 on consecutive cycles → out_data=1..8 on consecutive cycles; in_ready stays 1; occ=1 throughout.
- SKID=1 backpressure: out_ready=0, send payloads A, B, then offer C → occ=2, in_ready=0, C not taken. Raise out_ready → A, B, C emerge in order with no loss.
- Flush while FULL with in_valid=1 → next cycle occ=0, out_valid=0, out_ctrl=0; the offered payload never appears.
- SKID=0 stall: out_ready=0 with the head valid → in_ready=0, out_data held. out_ready=1 and in_valid=1 in the same cycle → head replaced next cycle, occ stays 1.
- Reset asserted while occ=2 → next cycle occ=0 and all outputs at their reset values.
